// File: rtl/pipe_pkg.sv
// Shared pipeline-stage types and constants.
// Also used by the decoder to detect NOP bubbles.
package pipe_pkg;

    typedef enum logic [1:0] {
        PS_EMPTY = 2'd0,
        PS_ONE   = 2'd1,
        PS_FULL  = 2'd2
    } pipe_state_t;

    localparam logic [15:0] NOP_WORD_DEFAULT = 16'h0000;

    function automatic logic [1:0] state_occ(input pipe_state_t s);
        logic [1:0] occ;
        occ = 2'd0;
        case (s)
            PS_ONE:  occ = 2'd1;
            PS_FULL: occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts inc_i cycles and holds at all-ones.
// Only reset clears it.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_o <= '0;
        end else if (inc_i && (cnt_o != '1)) begin
            cnt_o <= cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Multi-lane valid/ready pipeline register with a 2-entry skid buffer.
// ready_o depends only on state and reset, so downstream stalls never ripple upstream combinationally.
//
//   state    | meaning
//   ---------+----------------------------------------------
//   PS_EMPTY | nothing held, data_o = NOP lanes
//   PS_ONE   | main holds the head entry
//   PS_FULL  | main holds the head, skid holds the next one
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int                DATA_W   = 16,
    parameter int                LANES    = 2,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEFAULT),
    parameter int                CNT_W    = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic [LANES*DATA_W-1:0] data_i,
    input  logic                    flush_i,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [LANES*DATA_W-1:0] data_o,
    output logic [1:0]              occ_o,
    output logic [CNT_W-1:0]        stall_cnt_o
);

    localparam int              W       = LANES * DATA_W;
    localparam logic [W-1:0]    NOP_VEC = {LANES{NOP_WORD}};

    pipe_state_t  state_q, state_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         in_fire;
    logic         out_fire;

    assign ready_o  = (state_q != PS_FULL) & ~rst_i;
    assign valid_o  = (state_q != PS_EMPTY);
    assign occ_o    = state_occ(state_q);
    assign data_o   = main_q;
    assign in_fire  = valid_i & ready_o;
    assign out_fire = valid_o & ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= PS_EMPTY;
            main_q  <= NOP_VEC;
            skid_q  <= NOP_VEC;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // Vacated registers are refilled with NOP so data_o is NOP whenever valid_o is low.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = PS_EMPTY;
            main_d  = NOP_VEC;
            skid_d  = NOP_VEC;
        end else begin
            case (state_q)
                PS_EMPTY: begin
                    if (in_fire) begin
                        main_d  = data_i;
                        state_d = PS_ONE;
                    end
                end
                PS_ONE: begin
                    if (in_fire && out_fire) begin
                        main_d  = data_i;
                    end else if (in_fire) begin
                        skid_d  = data_i;
                        state_d = PS_FULL;
                    end else if (out_fire) begin
                        main_d  = NOP_VEC;
                        state_d = PS_EMPTY;
                    end
                end
                PS_FULL: begin
                    if (out_fire) begin
                        main_d  = skid_q;
                        skid_d  = NOP_VEC;
                        state_d = PS_ONE;
                    end
                end
                default: begin
                    state_d = PS_EMPTY;
                    main_d  = NOP_VEC;
                    skid_d  = NOP_VEC;
                end
            endcase
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (valid_o & ~ready_i),
        .cnt_o (stall_cnt_o)
    );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed vectors, corner sequences and a queue-based random model.
module tb_pipe_stage_skid;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_i = 1'b0;
    logic        ready_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [31:0] data_i = '0;

    logic        ready_o, valid_o;
    logic [31:0] data_o;
    logic [1:0]  occ_o;
    logic [15:0] stall_cnt;

    logic        ready4, valid4;
    logic [31:0] data4;
    logic [1:0]  occ4;
    logic [3:0]  stall4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(16), .LANES(2), .NOP_WORD(16'h0000), .CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
        .flush_i(flush_i), .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o),
        .occ_o(occ_o), .stall_cnt_o(stall_cnt));

    pipe_stage_skid #(.DATA_W(16), .LANES(2), .NOP_WORD(16'h0000), .CNT_W(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready4), .data_i(data_i),
        .flush_i(flush_i), .valid_o(valid4), .ready_i(ready_i), .data_o(data4),
        .occ_o(occ4), .stall_cnt_o(stall4));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; valid_i = 1'b1; data_i = 32'hDEAD_BEEF; ready_i = 1'b0; flush_i = 1'b0;
        repeat (5) begin
            tick();
            chk("rst_ready", 32'(ready_o), 32'd0);
            chk("rst_valid", 32'(valid_o), 32'd0);
            chk("rst_data",  data_o, 32'h0000_0000);
            chk("rst_occ",   32'(occ_o), 32'd0);
            chk("rst_stall", 32'(stall_cnt), 32'd0);
        end
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 32'(ready_o), 32'd1);
        chk("post_rst_valid", 32'(valid_o), 32'd0);
        valid_i = 1'b0;
    endtask

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        r;
        logic        f;
        logic        ev;
        logic [31:0] ed;
        logic [1:0]  eo;
        logic        er;
        logic [15:0] es;
    } vec_t;

    vec_t tbl [11];

    logic [31:0] q[$];
    int          m_cnt, m_cnt4;
    logic        m_ready, m_valid;

    initial begin
        // backpressure: 0x11,0x22 absorbed, 0x33 waits, then drained in order
        tbl[0]  = '{1'b1, 32'h11, 1'b0, 1'b0, 1'b1, 32'h11, 2'd1, 1'b1, 16'd0};
        tbl[1]  = '{1'b1, 32'h22, 1'b0, 1'b0, 1'b1, 32'h11, 2'd2, 1'b0, 16'd1};
        tbl[2]  = '{1'b1, 32'h33, 1'b0, 1'b0, 1'b1, 32'h11, 2'd2, 1'b0, 16'd2};
        tbl[3]  = '{1'b1, 32'h33, 1'b1, 1'b0, 1'b1, 32'h22, 2'd1, 1'b1, 16'd2};
        tbl[4]  = '{1'b1, 32'h33, 1'b1, 1'b0, 1'b1, 32'h33, 2'd1, 1'b1, 16'd2};
        tbl[5]  = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 32'h00, 2'd0, 1'b1, 16'd2};
        // flush while FULL with 0x44 offered, then 0x55 flows normally
        tbl[6]  = '{1'b1, 32'h01, 1'b0, 1'b0, 1'b1, 32'h01, 2'd1, 1'b1, 16'd2};
        tbl[7]  = '{1'b1, 32'h02, 1'b0, 1'b0, 1'b1, 32'h01, 2'd2, 1'b0, 16'd3};
        tbl[8]  = '{1'b1, 32'h44, 1'b0, 1'b1, 1'b0, 32'h00, 2'd0, 1'b1, 16'd4};
        tbl[9]  = '{1'b1, 32'h55, 1'b0, 1'b0, 1'b1, 32'h55, 2'd1, 1'b1, 16'd4};
        tbl[10] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 32'h00, 2'd0, 1'b1, 16'd4};

        do_reset();

        // streaming PC/instr pairs with ready_i held high
        ready_i = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            valid_i = 1'b1;
            data_i  = {16'hA000 + 16'(k), 16'(k)};
            tick();
            chk("stream_data",  data_o, {16'hA000 + 16'(k), 16'(k)});
            chk("stream_occ",   32'(occ_o), 32'd1);
            chk("stream_valid", 32'(valid_o), 32'd1);
            chk("stream_stall", 32'(stall_cnt), 32'd0);
        end
        valid_i = 1'b0;
        tick();
        chk("stream_drain", 32'(valid_o), 32'd0);

        do_reset();
        for (int i = 0; i < 11; i++) begin
            valid_i = tbl[i].v; data_i = tbl[i].d; ready_i = tbl[i].r; flush_i = tbl[i].f;
            tick();
            chk($sformatf("vec%0d_valid", i), 32'(valid_o), 32'(tbl[i].ev));
            chk($sformatf("vec%0d_data", i),  data_o, tbl[i].ed);
            chk($sformatf("vec%0d_occ", i),   32'(occ_o), 32'(tbl[i].eo));
            chk($sformatf("vec%0d_ready", i), 32'(ready_o), 32'(tbl[i].er));
            chk($sformatf("vec%0d_stall", i), 32'(stall_cnt), 32'(tbl[i].es));
        end
        flush_i = 1'b0;

        // saturation on the 4-bit counter instance
        do_reset();
        valid_i = 1'b1; data_i = 32'h66; ready_i = 1'b0;
        tick();
        valid_i = 1'b0;
        repeat (20) tick();
        chk("sat4_value", 32'(stall4), 32'hF);
        chk("sat16_value", 32'(stall_cnt), 32'd20);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("sat4_after_flush", 32'(stall4), 32'hF);
        chk("sat4_flush_valid", 32'(valid4), 32'd0);
        tick();
        chk("sat4_hold", 32'(stall4), 32'hF);
        rst = 1'b1;
        #1;
        chk("sat4_reset_clear", 32'(stall4), 32'd0);

        // async reset in FULL, asserted and released between edges
        do_reset();
        valid_i = 1'b1; ready_i = 1'b0;
        data_i = 32'h77; tick();
        data_i = 32'h88; tick();
        chk("async_pre_occ", 32'(occ_o), 32'd2);
        valid_i = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("async_valid", 32'(valid_o), 32'd0);
        chk("async_occ",   32'(occ_o), 32'd0);
        chk("async_ready", 32'(ready_o), 32'd0);
        chk("async_data",  data_o, 32'h0);
        #1 rst = 1'b0;
        ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("async_no_reappear", 32'(valid_o), 32'd0);
        end

        // random stimulus against a queue model
        do_reset();
        q.delete();
        m_cnt = 0;
        m_cnt4 = 0;
        for (int i = 0; i < 2000; i++) begin
            valid_i = ($urandom_range(0, 3) != 0);
            ready_i = ($urandom_range(0, 2) != 0);
            flush_i = ($urandom_range(0, 19) == 0);
            data_i  = $urandom;
            m_ready = (q.size() < 2);
            m_valid = (q.size() > 0);
            tick();
            if (m_valid && !ready_i) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt4 < 15) m_cnt4++;
            end
            if (flush_i) begin
                q.delete();
            end else begin
                if (m_valid && ready_i) void'(q.pop_front());
                if (valid_i && m_ready) q.push_back(data_i);
            end
            chk("rnd_valid", 32'(valid_o), 32'(q.size() > 0));
            chk("rnd_occ",   32'(occ_o), 32'(q.size()));
            chk("rnd_ready", 32'(ready_o), 32'(q.size() < 2));
            chk("rnd_data",  data_o, (q.size() > 0) ? q[0] : 32'h0);
            chk("rnd_stall", 32'(stall_cnt), 32'(m_cnt));
            chk("rnd_stall4", 32'(stall4), 32'(m_cnt4));
        end
        flush_i = 1'b0;
        valid_i = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised, multi-lane pipeline register with valid/ready handshake and a 2-entry skid buffer. It generalises the fixed IF/ID register so the same block can sit between any two stages: fetch→decode, decode→execute, and execute→memory. Backpressure from a stalled downstream stage never combinationally reaches the upstream stage. Flush injects NOP bubbles, and a saturating counter reports stall cycles for performance debug.

## Interface
Parameters:
- DATA_W, 16, width of one lane (one instruction, PC or operand word)
- LANES, 2, number of lanes carried under one handshake (e.g. PC + instruction)
- NOP_WORD, 16'h0000, value driven on every lane when no valid entry is presented
- CNT_W, 16, stall counter width

Ports:
- clk_i  in  1  clock; all state changes on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- valid_i  in  1  upstream has an entry on data_i
- ready_o  out  1  stage can accept an entry this cycle
- data_i  in  LANES*DATA_W  upstream payload; lane k at [k*DATA_W +: DATA_W]
- flush_i  in  1  synchronous flush of all held entries (branch/jump redirect)
- valid_o  out  1  data_o holds a valid entry
- ready_i  in  1  downstream accepts data_o this cycle
- data_o  out  LANES*DATA_W  head entry; {LANES{NOP_WORD}} when valid_o=0
- occ_o  out  2  entries held: 0, 1 or 2
- stall_cnt_o  out  CNT_W  cycles with valid_o=1 and ready_i=0, saturating

## Operation
- Definitions:
  - in_fire = valid_i & ready_o
  - out_fire = valid_o & ready_i
- Storage: main register (head, drives data_o) and skid register (second entry).
- States: EMPTY (occ 0), ONE (occ 1, main valid), FULL (occ 2, main and skid valid).
- ready_o = (state != FULL) & ~rst_i. It is a function of state only and has no path from ready_i.
- valid_o = (state != EMPTY).
- Transitions without flush:
  - EMPTY: in_fire → main<=data_i, ONE; else stay.
  - ONE: in_fire & out_fire → main<=data_i, ONE. in_fire only → skid<=data_i, FULL. out_fire only → EMPTY. Neither → stay.
  - FULL: out_fire → main<=skid, ONE; else stay. No in_fire is possible in FULL.
- Flush (flush_i=1) has the highest priority:
  - Next state EMPTY; main and skid <= {LANES{NOP_WORD}}.
  - An in_fire in the same cycle is discarded. Upstream sees ready_o=1 and treats the entry as consumed.
  - An out_fire in the same cycle still counts as delivered downstream.
- Ordering: entries leave in arrival order. No entry is duplicated or dropped except by flush.
- Stall counter:
  - Increments on every cycle with valid_o & ~ready_i.
  - Holds at all-ones.
  - Not affected by flush; cleared only by reset.
- Reset, asynchronous: state EMPTY, main/skid = {LANES{NOP_WORD}}, stall_cnt_o=0.
  - While rst_i=1: valid_o=0, ready_o=0, occ_o=0, data_o={LANES{NOP_WORD}}.
  - Reset mid-operation drops all held entries immediately, without waiting for a clock edge.

## Timing
- Latency: in_fire at edge N in EMPTY gives valid_o=1 with that data after edge N.
- Throughput: 1 entry/cycle sustained while ready_i=1.
- data_o, valid_o and occ_o are registered outputs.
- ready_o is combinational only from state and rst_i.
- Backpressure:
  - ready_i falls in ONE → ready_o is still 1 that cycle, one more entry is absorbed into skid, then ready_o=0.
  - ready_i rises in FULL → the head is delivered that edge; ready_o=1 the next cycle.
- First cycle after rst_i deasserts: ready_o=1 and valid_o=0.

## Structure
- Shared package pipe_pkg:
  - pipe_state_t enum {PS_EMPTY, PS_ONE, PS_FULL}.
  - Default NOP_WORD constant, reused by decoder NOP detection.
- Sub-module sat_counter #(CNT_W) (clk_i, rst_i, inc_i, cnt_o) for stall_cnt_o. The same counter is reused by later performance counters.
- Main/skid registers are one LANES*DATA_W vector each; no per-lane logic beyond slicing.

## Test plan
- Reset: hold rst_i 5 cycles with valid_i=1 → ready_o=0, valid_o=0, data_o=32'h0000_0000, occ_o=0, stall_cnt_o=0. After release, ready_o=1.
- Streaming: ready_i=1; push PC/instr pairs {0x0001,0xA001}..{0x0008,0xA008} back-to-back → same 8 pairs on data_o in order, one cycle after each accept; occ_o stays 1; no stalls counted.
- Backpressure: push 0x11, 0x22, 0x33 with ready_i=0 → 0x11 and 0x22 accepted, ready_o=0 while 0x33 waits, occ_o=2. Raise ready_i → 0x11, 0x22, 0x33 delivered in order; stall_cnt_o equals the cycles spent with ready_i=0 and valid_o=1.
- Flush while FULL with valid_i=1, data_i=0x44 → next cycle valid_o=0, occ_o=0, data_o=NOP_WORD lanes, 0x44 never appears. Next push 0x55 appears normally.
- Saturation: CNT_W=4, hold valid_o=1, ready_i=0 for 20 cycles → stall_cnt_o stops at 4'hF. Flush leaves it at 4'hF; only reset clears it.
- Async reset mid-FULL, between clock edges → valid_o=0 and occ_o=0 without a clock edge; held entries never reappear after release.
